// File: rtl/fpr_file_dp_if.sv
// Decode/writeback-side bundle of the FP register file: read/write addresses,
// write data, issue info, and the read buses and status flags returned.
interface fpr_file_dp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   Rs;
  logic [ADDR_W-1:0]   Rt;
  logic [ADDR_W-1:0]   Rd;
  logic                Rdst;
  logic                rdDbl;
  logic                regWr;
  logic                wrDbl;
  logic [2*DATA_W-1:0] busW;
  logic                issueVld;
  logic [ADDR_W-1:0]   issueDst;
  logic                issueDbl;
  logic [2*DATA_W-1:0] busA;
  logic [2*DATA_W-1:0] busB;
  logic                busyA;
  logic                busyB;
  logic                alignErr;

  modport master (
    output Rs, Rt, Rd, Rdst, rdDbl, regWr, wrDbl, busW, issueVld, issueDst, issueDbl,
    input  busA, busB, busyA, busyB, alignErr
  );

  modport slave (
    input  Rs, Rt, Rd, Rdst, rdDbl, regWr, wrDbl, busW, issueVld, issueDst, issueDbl,
    output busA, busB, busyA, busyB, alignErr
  );
endinterface

// File: rtl/fpr_file_dp.sv
// FP register file with even/odd double pairing, optional same-cycle write bypass,
// a per-register busy scoreboard and a sticky double-alignment error flag.
module fpr_file_dp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1
) (
  input logic          clk,
  input logic          reset,
  fpr_file_dp_if.slave rf
);

  logic [DATA_W-1:0]   regsR [NUM_REGS];
  logic [NUM_REGS-1:0] busyR;
  logic                alignErrR;

  logic [ADDR_W-1:0]   rwS;
  logic [NUM_REGS-1:0] wrEnS;
  logic [NUM_REGS-1:0] issSetS;
  logic [DATA_W-1:0]   wrValS [NUM_REGS];
  logic [DATA_W-1:0]   rdValS [NUM_REGS];
  logic                alignSetS;

  function automatic logic [ADDR_W-1:0] evenOf(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b0};
  endfunction

  function automatic logic [ADDR_W-1:0] oddOf(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:1], 1'b1};
  endfunction

  assign rwS = rf.Rdst ? rf.Rd : rf.Rt;

  assign alignSetS = (rf.regWr & rf.wrDbl & rwS[0])
                   | (rf.rdDbl & (rf.Rs[0] | rf.Rt[0]))
                   | (rf.issueVld & rf.issueDbl & rf.issueDst[0]);

  // Per-register write enables/data, issue set mask and read value (with optional forwarding)
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      wrEnS[i]   = 1'b0;
      wrValS[i]  = {DATA_W{1'b0}};
      issSetS[i] = 1'b0;
      if (rf.regWr) begin
        if (rf.wrDbl) begin
          if (ADDR_W'(i) == evenOf(rwS)) begin
            wrEnS[i]  = 1'b1;
            wrValS[i] = rf.busW[DATA_W-1:0];
          end else if (ADDR_W'(i) == oddOf(rwS)) begin
            wrEnS[i]  = 1'b1;
            wrValS[i] = rf.busW[2*DATA_W-1:DATA_W];
          end else begin
            wrEnS[i] = 1'b0;
          end
        end else if (ADDR_W'(i) == rwS) begin
          wrEnS[i]  = 1'b1;
          wrValS[i] = rf.busW[DATA_W-1:0];
        end else begin
          wrEnS[i] = 1'b0;
        end
      end else begin
        wrEnS[i] = 1'b0;
      end
      if (rf.issueVld) begin
        if (rf.issueDbl) begin
          issSetS[i] = (evenOf(ADDR_W'(i)) == evenOf(rf.issueDst));
        end else begin
          issSetS[i] = (ADDR_W'(i) == rf.issueDst);
        end
      end else begin
        issSetS[i] = 1'b0;
      end
      // Forwarding is per register, so a single write lands in only one half of a pair read
      if ((BYPASS != 0) && wrEnS[i]) begin
        rdValS[i] = wrValS[i];
      end else begin
        rdValS[i] = regsR[i];
      end
    end
  end

  // Read buses and busy flags; busy reflects registered state only
  always_comb begin
    if (rf.rdDbl) begin
      rf.busA  = {rdValS[oddOf(rf.Rs)], rdValS[evenOf(rf.Rs)]};
      rf.busB  = {rdValS[oddOf(rf.Rt)], rdValS[evenOf(rf.Rt)]};
      rf.busyA = busyR[oddOf(rf.Rs)] | busyR[evenOf(rf.Rs)];
      rf.busyB = busyR[oddOf(rf.Rt)] | busyR[evenOf(rf.Rt)];
    end else begin
      rf.busA  = {{DATA_W{1'b0}}, rdValS[rf.Rs]};
      rf.busB  = {{DATA_W{1'b0}}, rdValS[rf.Rt]};
      rf.busyA = busyR[rf.Rs];
      rf.busyB = busyR[rf.Rt];
    end
  end

  assign rf.alignErr = alignErrR;

  // Register array, scoreboard (set beats clear) and sticky alignment flag
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regsR[i] <= {DATA_W{1'b0}};
      end
      busyR     <= {NUM_REGS{1'b0}};
      alignErrR <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wrEnS[i]) begin
          regsR[i] <= wrValS[i];
        end
      end
      busyR <= issSetS | (busyR & ~wrEnS);
      if (alignSetS) begin
        alignErrR <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fpr_file_dp.sv
// Directed bench for fpr_file_dp: one bypassing and one non-bypassing instance
// driven by identical stimulus, checked against hand-computed values.
module tb_fpr_file_dp;
  logic clk;
  logic reset;
  int   nAssert;
  int   nFail;

  fpr_file_dp_if #(.DATA_W(32), .ADDR_W(5)) if0 ();
  fpr_file_dp_if #(.DATA_W(32), .ADDR_W(5)) if1 ();

  fpr_file_dp #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .BYPASS(1)) dut0 (
    .clk(clk), .reset(reset), .rf(if0.slave)
  );
  fpr_file_dp #(.DATA_W(32), .NUM_REGS(32), .ADDR_W(5), .BYPASS(0)) dut1 (
    .clk(clk), .reset(reset), .rf(if1.slave)
  );

  assign if1.Rs       = if0.Rs;
  assign if1.Rt       = if0.Rt;
  assign if1.Rd       = if0.Rd;
  assign if1.Rdst     = if0.Rdst;
  assign if1.rdDbl    = if0.rdDbl;
  assign if1.regWr    = if0.regWr;
  assign if1.wrDbl    = if0.wrDbl;
  assign if1.busW     = if0.busW;
  assign if1.issueVld = if0.issueVld;
  assign if1.issueDst = if0.issueDst;
  assign if1.issueDbl = if0.issueDbl;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nAssert++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    if0.Rs = 5'd0; if0.Rt = 5'd0; if0.Rd = 5'd0; if0.Rdst = 1'b0;
    if0.rdDbl = 1'b0; if0.regWr = 1'b0; if0.wrDbl = 1'b0; if0.busW = 64'd0;
    if0.issueVld = 1'b0; if0.issueDst = 5'd0; if0.issueDbl = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    nAssert = 0;
    nFail   = 0;
    reset   = 1'b1;
    idle();
    tick();
    reset = 1'b0;

    // T1: populate reg3 and a busy bit, then reset with a write that must be ignored
    if0.Rd = 5'd3; if0.Rdst = 1'b1; if0.busW = 64'h3F800000; if0.regWr = 1'b1;
    if0.issueVld = 1'b1; if0.issueDst = 5'd3;
    tick();
    idle(); if0.Rs = 5'd3; #1;
    chk("t1_pre_busA", if0.busA, 64'h00000000_3F800000);
    chk("t1_pre_busyA", {63'd0, if0.busyA}, 64'd1);
    reset = 1'b1;
    if0.Rd = 5'd3; if0.Rdst = 1'b1; if0.busW = 64'h1234; if0.regWr = 1'b1;
    if0.issueVld = 1'b1; if0.issueDst = 5'd4;
    tick();
    reset = 1'b0;
    idle(); if0.Rs = 5'd3; if0.Rt = 5'd4; #1;
    chk("t1_rst_busA", if0.busA, 64'd0);
    chk("t1_rst_busA_nb", if1.busA, 64'd0);
    chk("t1_rst_busyA", {63'd0, if0.busyA}, 64'd0);
    chk("t1_rst_busyB", {63'd0, if0.busyB}, 64'd0);
    chk("t1_rst_align", {63'd0, if0.alignErr}, 64'd0);

    // T2: write destination select
    if0.Rt = 5'd4; if0.Rd = 5'd9; if0.Rdst = 1'b1; if0.busW = 64'hAB; if0.regWr = 1'b1;
    tick();
    idle(); if0.Rs = 5'd9; if0.Rt = 5'd4; #1;
    chk("t2_rd_reg9", if0.busA, 64'hAB);
    chk("t2_rd_reg4_unch", if0.busB, 64'd0);
    if0.Rt = 5'd4; if0.Rd = 5'd9; if0.Rdst = 1'b0; if0.busW = 64'hAB; if0.regWr = 1'b1;
    tick();
    idle(); if0.Rt = 5'd4; #1;
    chk("t2_rt_reg4", if0.busB, 64'hAB);

    // T3: double write and reads
    if0.Rd = 5'd6; if0.Rdst = 1'b1; if0.wrDbl = 1'b1; if0.regWr = 1'b1;
    if0.busW = 64'h40090000_54442D18;
    tick();
    idle(); if0.rdDbl = 1'b1; if0.Rs = 5'd6; if0.Rt = 5'd6; #1;
    chk("t3_dbl_busA", if0.busA, 64'h40090000_54442D18);
    chk("t3_dbl_busB", if0.busB, 64'h40090000_54442D18);
    idle(); if0.Rs = 5'd7; #1;
    chk("t3_single_odd", if0.busA, 64'h00000000_40090000);

    // T4: same-cycle bypass vs. registered read
    idle(); if0.Rd = 5'd2; if0.Rdst = 1'b1; if0.busW = 64'h55; if0.regWr = 1'b1; if0.Rs = 5'd2; #1;
    chk("t4_byp_busA", if0.busA, 64'h55);
    chk("t4_nobyp_old", if1.busA, 64'd0);
    tick();
    idle(); if0.Rs = 5'd2; #1;
    chk("t4_nobyp_next", if1.busA, 64'h55);
    // single write into the odd half of a double read forwards only that half
    idle(); if0.rdDbl = 1'b1; if0.Rs = 5'd6;
    if0.Rd = 5'd7; if0.Rdst = 1'b1; if0.busW = 64'hFFFFFFFF_00000077; if0.regWr = 1'b1; #1;
    chk("t4_half_byp", if0.busA, 64'h00000077_54442D18);
    chk("t4_half_nobyp", if1.busA, 64'h40090000_54442D18);
    tick();

    // T5: scoreboard
    idle(); if0.issueVld = 1'b1; if0.issueDbl = 1'b1; if0.issueDst = 5'd10;
    tick();
    idle(); if0.Rs = 5'd11; if0.Rt = 5'd12; #1;
    chk("t5_busy_odd", {63'd0, if0.busyA}, 64'd1);
    chk("t5_busy_other", {63'd0, if0.busyB}, 64'd0);
    idle(); if0.Rs = 5'd11;
    if0.regWr = 1'b1; if0.wrDbl = 1'b1; if0.Rd = 5'd10; if0.Rdst = 1'b1; if0.busW = 64'h1;
    if0.issueVld = 1'b1; if0.issueDbl = 1'b1; if0.issueDst = 5'd10;
    tick();
    idle(); if0.Rs = 5'd11; #1;
    chk("t5_set_wins", {63'd0, if0.busyA}, 64'd1);
    if0.regWr = 1'b1; if0.wrDbl = 1'b1; if0.Rd = 5'd10; if0.Rdst = 1'b1; if0.busW = 64'h2; #1;
    chk("t5_clear_not_same_cycle", {63'd0, if0.busyA}, 64'd1);
    tick();
    idle(); if0.Rs = 5'd11; if0.Rt = 5'd10; #1;
    chk("t5_cleared_A", {63'd0, if0.busyA}, 64'd0);
    chk("t5_cleared_B", {63'd0, if0.busyB}, 64'd0);
    chk("t5_no_align", {63'd0, if0.alignErr}, 64'd0);

    // T6: misaligned double read, sticky flag, masked address
    idle(); if0.rdDbl = 1'b1; if0.Rs = 5'd5; #1;
    chk("t6_masked_read", if0.busA, 64'h00000000_000000AB);
    chk("t6_align_before", {63'd0, if0.alignErr}, 64'd0);
    tick();
    idle(); #1;
    chk("t6_align_set", {63'd0, if0.alignErr}, 64'd1);
    tick();
    tick();
    chk("t6_align_sticky", {63'd0, if0.alignErr}, 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_align_reset", {63'd0, if0.alignErr}, 64'd0);

    // Misaligned double write proceeds on the masked pair
    idle(); if0.regWr = 1'b1; if0.wrDbl = 1'b1; if0.Rd = 5'd13; if0.Rdst = 1'b1;
    if0.busW = 64'h00000011_00000022;
    tick();
    idle(); if0.rdDbl = 1'b1; if0.Rs = 5'd12; #1;
    chk("t6_wr_align", {63'd0, if0.alignErr}, 64'd1);
    chk("t6_wr_masked", if0.busA, 64'h00000011_00000022);
    idle(); #1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end
endmodule
